// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg : shared types and constants for the instruction fetch unit
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_t;

  localparam int unsigned PC_STEP = 4;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if : SRAM read bus plus instruction hand-off to the datapath
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output mem_addr, mem_read_en, instr, instr_pc, instr_valid,
    input  mem_rdata, mem_ready, instr_ready
  );

  modport slave (
    input  mem_addr, mem_read_en, instr, instr_pc, instr_valid,
    output mem_rdata, mem_ready, instr_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_pc.sv
// ---------------------------------------------------------------------------
// fetch_pc : program counter, pending-redirect register and misalign detection
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pc_sel_t           sel,
  input  logic              pend_we,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign_err
);

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pend_pc;

  // Targets are always word aligned; the low bits only feed the sticky flag.
  assign target = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      pend_pc      <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (sel)
        PC_INC:   pc <= pc + ADDR_W'(PC_STEP);
        PC_REDIR: pc <= target;
        PC_PEND:  pc <= pend_pc;
        default:  pc <= pc;
      endcase
      if (pend_we)
        pend_pc <= target;
      if (redirect_en && (redirect_pc[1:0] != 2'b00))
        misalign_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit : fetch FSM, instruction register and hand-off counter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt,
  input  logic                redirect_en,
  input  logic [ADDR_W-1:0]   redirect_pc,
  instr_fetch_unit_if.master  bus,
  output logic                busy,
  output logic                misalign_err,
  output logic [CNT_W-1:0]    fetch_count
);

  fetch_state_t      state;
  pc_sel_t           pc_sel;
  logic              pend_we;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  count;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (pc_sel),
    .pend_we      (pend_we),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .pc           (pc),
    .misalign_err (misalign_err)
  );

  // A redirect that coincides with mem_ready wins over both increment and the
  // pending target, so the most recent branch decision is always honoured.
  always_comb begin
    pc_sel  = PC_HOLD;
    pend_we = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (redirect_en) pc_sel = PC_REDIR;
      end
      REQ: begin
        if (bus.mem_ready)    pc_sel  = redirect_en ? PC_REDIR : PC_INC;
        else if (redirect_en) pend_we = 1'b1;
      end
      DISCARD: begin
        if (bus.mem_ready)    pc_sel  = redirect_en ? PC_REDIR : PC_PEND;
        else if (redirect_en) pend_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr    <= '0;
      instr_pc <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= REQ;
        end
        REQ: begin
          if (bus.mem_ready && !redirect_en) begin
            instr    <= bus.mem_rdata;
            instr_pc <= pc;
            state    <= HOLD;
          end else if (redirect_en && !bus.mem_ready) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus.mem_ready) state <= REQ;
        end
        HOLD: begin
          if (redirect_en) begin
            state <= REQ;
          end else if (bus.instr_ready) begin
            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            state <= halt ? IDLE : REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = pc;
  assign bus.mem_read_en = (state == REQ) || (state == DISCARD);
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = (state == HOLD);
  assign busy            = (state != IDLE);
  assign fetch_count     = count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit : directed bench with a programmable-latency memory
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int n_checks;
  int n_fail;
  int wait_cycles;
  int wcnt;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt         (halt),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .bus          (bus),
    .busy         (busy),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers wait_cycles cycles after a request appears; data encodes the address.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        wcnt = 0;
      end
      if (bus.mem_read_en) begin
        if (wcnt >= wait_cycles) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = {bus.mem_addr[23:0], 8'h13};
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    wait_cycles     = 0;
    rst_n           = 1'b0;
    start           = 1'b0;
    halt            = 1'b0;
    redirect_en     = 1'b0;
    redirect_pc     = '0;
    bus.instr_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk ("rst_mem_addr", bus.mem_addr, 32'h0);
    chk1("rst_read_en", bus.mem_read_en, 1'b0);
    chk ("rst_instr", bus.instr, 32'h0);
    chk ("rst_instr_pc", bus.instr_pc, 32'h0);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_misalign", misalign_err, 1'b0);
    chk ("rst_count", {16'h0, fetch_count}, 32'h0);
    rst_n = 1'b1;

    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    start = 1'b1;

    // Zero-wait memory: one instruction every two cycles.
    @(negedge clk);
    start = 1'b0;
    chk1("t1_req0_en", bus.mem_read_en, 1'b1);
    chk ("t1_req0_addr", bus.mem_addr, 32'h0);
    chk1("t1_req0_busy", busy, 1'b1);
    @(negedge clk);
    chk1("t1_hold0_valid", bus.instr_valid, 1'b1);
    chk ("t1_hold0_instr", bus.instr, 32'h0000_0013);
    chk ("t1_hold0_pc", bus.instr_pc, 32'h0);
    chk1("t1_hold0_en", bus.mem_read_en, 1'b0);
    @(negedge clk);
    chk1("t1_req1_valid", bus.instr_valid, 1'b0);
    chk ("t1_req1_addr", bus.mem_addr, 32'h4);
    chk ("t1_req1_count", {16'h0, fetch_count}, 32'd1);
    @(negedge clk);
    chk1("t1_hold1_valid", bus.instr_valid, 1'b1);
    chk ("t1_hold1_pc", bus.instr_pc, 32'h4);
    chk ("t1_hold1_instr", bus.instr, 32'h0000_0413);
    @(negedge clk);
    chk ("t1_req2_addr", bus.mem_addr, 32'h8);
    chk ("t1_req2_count", {16'h0, fetch_count}, 32'd2);
    @(negedge clk);
    chk ("t1_hold2_pc", bus.instr_pc, 32'h8);
    chk ("t1_hold2_instr", bus.instr, 32'h0000_0813);
    @(negedge clk);
    chk ("t1_count3", {16'h0, fetch_count}, 32'd3);
    chk ("t1_req3_addr", bus.mem_addr, 32'hC);
    wait_cycles = 3;
    @(negedge clk);
    chk ("t1_hold3_pc", bus.instr_pc, 32'hC);

    // Three wait states at 0x10: request held for four cycles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t2_wait_en", bus.mem_read_en, 1'b1);
      chk ("t2_wait_addr", bus.mem_addr, 32'h10);
      chk1("t2_wait_valid", bus.instr_valid, 1'b0);
    end
    @(negedge clk);
    chk1("t2_valid", bus.instr_valid, 1'b1);
    chk ("t2_pc", bus.instr_pc, 32'h10);
    chk ("t2_instr", bus.instr, 32'h0000_1013);
    chk ("t2_count", {16'h0, fetch_count}, 32'd4);

    // Redirect to 0x40 while the read at 0x14 is outstanding.
    @(negedge clk);
    chk ("t3_req_addr", bus.mem_addr, 32'h14);
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redirect_en = 1'b0;
      chk ("t3_discard_addr", bus.mem_addr, 32'h14);
      chk1("t3_discard_en", bus.mem_read_en, 1'b1);
      chk1("t3_discard_valid", bus.instr_valid, 1'b0);
    end
    @(negedge clk);
    chk ("t3_new_addr", bus.mem_addr, 32'h40);
    chk1("t3_new_valid", bus.instr_valid, 1'b0);
    wait_cycles = 0;
    @(negedge clk);
    chk1("t3_no_stale", bus.instr_valid, 1'b0);
    @(negedge clk);
    chk1("t3_valid", bus.instr_valid, 1'b1);
    chk ("t3_pc", bus.instr_pc, 32'h40);
    chk ("t3_instr", bus.instr, 32'h0000_4013);
    chk ("t3_count", {16'h0, fetch_count}, 32'd5);

    // Redirect in HOLD squashes the instruction despite instr_ready.
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_en = 1'b0;
    chk ("t4_count", {16'h0, fetch_count}, 32'd5);
    chk ("t4_addr", bus.mem_addr, 32'h100);
    chk1("t4_valid", bus.instr_valid, 1'b0);
    chk1("t4_misalign0", misalign_err, 1'b0);
    @(negedge clk);
    chk ("t4_pc", bus.instr_pc, 32'h100);
    chk ("t4_instr", bus.instr, 32'h0001_0013);
    redirect_en = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_en = 1'b0;
    chk1("t4_misalign1", misalign_err, 1'b1);
    chk ("t4_mis_addr", bus.mem_addr, 32'h100);
    chk ("t4_mis_count", {16'h0, fetch_count}, 32'd5);
    @(negedge clk);
    chk ("t4_mis_pc", bus.instr_pc, 32'h100);

    // Halt raised during REQ takes effect at the following hand-off.
    @(negedge clk);
    halt = 1'b1;
    chk ("t5_req_addr", bus.mem_addr, 32'h104);
    chk ("t5_req_count", {16'h0, fetch_count}, 32'd6);
    @(negedge clk);
    chk1("t5_valid", bus.instr_valid, 1'b1);
    chk ("t5_pc", bus.instr_pc, 32'h104);
    chk ("t5_instr", bus.instr, 32'h0001_0413);
    @(negedge clk);
    halt = 1'b0;
    chk1("t5_idle_busy", busy, 1'b0);
    chk1("t5_idle_en", bus.mem_read_en, 1'b0);
    chk1("t5_idle_valid", bus.instr_valid, 1'b0);
    chk ("t5_idle_count", {16'h0, fetch_count}, 32'd7);
    chk ("t5_idle_addr", bus.mem_addr, 32'h108);
    @(negedge clk);
    chk1("t5_still_idle", busy, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("t5_resume_en", bus.mem_read_en, 1'b1);
    chk ("t5_resume_addr", bus.mem_addr, 32'h108);
    @(negedge clk);
    chk ("t5_resume_pc", bus.instr_pc, 32'h108);
    chk ("t5_resume_instr", bus.instr, 32'h0001_0813);
    bus.instr_ready = 1'b0;

    // Counter saturation from a preloaded value.
    @(negedge clk);
    chk1("t6_stall_valid", bus.instr_valid, 1'b1);
    chk ("t6_stall_count", {16'h0, fetch_count}, 32'd7);
    force dut.count = 16'hFFFE;
    #1;
    release dut.count;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk ("t6_count_max", {16'h0, fetch_count}, 32'h0000_FFFF);
    @(negedge clk);
    chk1("t6_hold_valid", bus.instr_valid, 1'b1);
    wait_cycles = 5;
    @(negedge clk);
    chk ("t6_count_sat", {16'h0, fetch_count}, 32'h0000_FFFF);
    chk1("t6_req_en", bus.mem_read_en, 1'b1);
    chk ("t6_req_addr", bus.mem_addr, 32'h110);

    // Asynchronous reset in the middle of an outstanding read.
    #2;
    rst_n = 1'b0;
    #1;
    chk1("t7_en", bus.mem_read_en, 1'b0);
    chk ("t7_addr", bus.mem_addr, 32'h0);
    chk1("t7_busy", busy, 1'b0);
    chk1("t7_valid", bus.instr_valid, 1'b0);
    chk ("t7_instr", bus.instr, 32'h0);
    chk ("t7_instr_pc", bus.instr_pc, 32'h0);
    chk ("t7_count", {16'h0, fetch_count}, 32'h0);
    chk1("t7_misalign", misalign_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk1("t7_post_busy", busy, 1'b0);
    chk1("t7_post_valid", bus.instr_valid, 1'b0);
    chk1("t7_post_en", bus.mem_read_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
